dct_row_feeder: RTL

Upstream sequencer for the 1-D DCT systolic array. It accepts one row of N pixel samples over a valid/ready stream and stores it in a ping-pong row buffer. It then replays the row into the array's per-row inputs `x`, `sumDiffSel` and `load`, in butterfly order, as two consecutive passes: an even pass (sum) and an odd pass (difference). One instance drives one array row.

---
 rtl/dct_row_feeder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dct_row_feeder.sv
// Ping-pong row buffer feeding one DCT array row: even (sum) pass, then odd (difference) pass.
// Optional JPEG level shift at write time when DCT_FEEDER_LEVEL_SHIFT_EN is defined.
module dct_row_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] x,
    output logic                  sumDiffSel,
    output logic                  load,
    output logic                  active,
    output logic [15:0]           rows_done
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [2][N];
    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q;
    logic [IW-1:0]         wr_idx_q;
    logic                  rd_bank_q, rd_bank_d;
    logic [IW-1:0]         s_q, s_d;
    state_t                state_q, state_d;

    logic [DATA_WIDTH-1:0] x_q;
    logic                  sds_q;
    logic                  load_q;
    logic                  active_q;
    logic [15:0]           rows_done_q;

    logic                  wr_fire;
    logic                  wr_last;
    logic                  rd_done;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [IW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_sample;

    // Butterfly order: even slots walk up from 0, odd slots walk down from N-1.
    function automatic logic [IW-1:0] slot_idx(input logic [IW-1:0] s);
        if (s[0]) begin
            slot_idx = LAST - (s >> 1);
        end else begin
            slot_idx = s >> 1;
        end
    endfunction

    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = wr_fire && (wr_idx_q == LAST);
    assign rd_done  = (state_q == ODD) && (s_q == LAST);

`ifdef DCT_FEEDER_LEVEL_SHIFT_EN
    localparam logic [DATA_WIDTH-1:0] HALF = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    assign wr_data = in_data - HALF;
`else
    assign wr_data = in_data;
`endif

    // Next-state uses full_d so a row completing this cycle starts EVEN on the very next cycle.
    always_comb begin
        full_d    = full_q;
        state_d   = state_q;
        s_d       = s_q;
        rd_bank_d = rd_bank_q;
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (full_d[rd_bank_q]) begin
                    state_d = EVEN;
                    s_d     = '0;
                end
            end
            EVEN: begin
                if (s_q == LAST) begin
                    state_d = ODD;
                    s_d     = '0;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            ODD: begin
                if (s_q == LAST) begin
                    rd_bank_d = ~rd_bank_q;
                    s_d       = '0;
                    state_d   = full_d[~rd_bank_q] ? EVEN : IDLE;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase
    end

    assign rd_idx    = slot_idx(s_d);
    assign rd_sample = mem_q[rd_bank_d][rd_idx];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_idx_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            s_q         <= '0;
            state_q     <= IDLE;
            x_q         <= '0;
            sds_q       <= 1'b0;
            load_q      <= 1'b0;
            active_q    <= 1'b0;
            rows_done_q <= '0;
        end else begin
            full_q    <= full_d;
            rd_bank_q <= rd_bank_d;
            s_q       <= s_d;
            state_q   <= state_d;
            if (wr_fire) begin
                wr_idx_q <= wr_last ? '0 : wr_idx_q + 1'b1;
                if (wr_last) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            if (rd_done) begin
                rows_done_q <= rows_done_q + 16'd1;
            end
            active_q <= (state_d != IDLE);
            sds_q    <= (state_d == EVEN);
            load_q   <= (state_d != IDLE) && (s_d == '0);
            x_q      <= (state_d != IDLE) ? rd_sample : '0;
        end
    end

    assign x          = x_q;
    assign sumDiffSel = sds_q;
    assign load       = load_q;
    assign active     = active_q;
    assign rows_done  = rows_done_q;

endmodule
